sram_dp_be: RTL and testbench
=============================

Name: sram_dp_be

Overview:
- Parametrised simple-dual-port (1 write, 1 read) synchronous SRAM. Successor to the single-port read/write-bit SRAM.
- Adds separate read and write ports, per-byte write enables, and a configurable read latency with a valid strobe.
- Adds a defined read-during-write policy and a self-clearing init sequence after reset.
- Used as the standard on-chip buffer for block-level UVM benches and datapath stores.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2^ADDR_WIDTH.
- READ_LATENCY, 1, edges from rd_en sample to rd_data/rd_valid; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write collision policy: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when init clear is complete and ports are accepted.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i selects data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe marking valid rd_data.

Behaviour:
- Reset (rst high at an edge):
  - ready<=0, rd_valid<=0 and all pipeline valids<=0, rd_data<=0, clear pointer<=0, FSM<=CLEAR.
  - rst takes priority over everything, including mid-clear and mid-read; in-flight reads are discarded.
- FSM CLEAR:
  - Each edge with rst low writes 0 to mem[clr_ptr] and increments clr_ptr.
  - At the edge where clr_ptr==DEPTH-1: write 0, go to RUN, set ready<=1.
  - ready therefore rises exactly DEPTH edges after the first edge with rst low.
  - wr_en and rd_en are ignored in CLEAR: no array write, no rd_valid.
- FSM RUN:
  - Stays in RUN until rst.
- Write (RUN, wr_en=1, wr_addr<DEPTH):
  - At the edge, bytes with wr_be[i]=1 are updated; other bytes are unchanged.
  - wr_be=0 is a legal no-op.
  - wr_addr>=DEPTH: write dropped silently.
- Read (RUN, rd_en=1):
  - READ_LATENCY=1: rd_data and rd_valid=1 appear after the same edge that samples rd_en.
  - READ_LATENCY=2: one extra output register stage.
  - Fully pipelined: back-to-back reads give a valid every cycle.
  - rd_addr>=DEPTH returns 0 with rd_valid=1.
  - rd_data holds its last value while rd_valid=0.
- Collision (wr_en and rd_en, same in-range address, same edge):
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the word after the byte-enable merge (old bytes where wr_be=0).
- Write-then-read on the next cycle always returns the new data under both modes.
- No other ordering hazards exist.
- Reads and writes to different addresses are fully independent.

Decomposition:
- Package sram_pkg:
  - state enum {ST_CLEAR, ST_RUN}.
  - RDW_OLD=0, RDW_NEW=1.
  - function byte_merge(old, new, be).
- Sub-module sram_init_ctrl: CLEAR/RUN FSM, clear pointer, ready, and the muxed internal write port.
- Top holds the array, collision logic and read pipeline.

Test Plan:
- Reset, then hold rst low -> ready=0 for 256 cycles, ready=1 at edge 256; reading every address returns 0.
- Write 0xDEADBEEF to addr 0x10 with be=0xF, then write 0x000000AA with be=0x1 -> read 0x10 returns 0xDEADBEAA.
- Collision at addr 0x20 (old 0x11111111; write 0x22222222, be=0x3) -> RDW_MODE=0 returns 0x11111111; RDW_MODE=1 returns 0x11112222.
- READ_LATENCY=2, reads of addrs 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles starting 2 edges after the first rd_en, data in order.
- Assert rst for one cycle mid-clear (clr_ptr=100) and during an in-flight read -> rd_valid never pulses; clear restarts at 0; ready rises 256 edges after rst drops.
- DEPTH=200, ADDR_WIDTH=8: write to addr 250 then read addr 250 -> rd_data=0, rd_valid=1, and mem[250 mod anything] unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types, collision-policy codes and the byte-merge helper
//               for the simple-dual-port byte-enable SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_init_ctrl
// Description : CLEAR/RUN sequencer. Zeroes the array after reset, then hands
//               the internal write port to the user write interface.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    output logic                    o_ready,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic                    r_ready;
    logic                    w_wr_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == c_LAST) begin
                        r_state   <= ST_RUN;
                        r_ready   <= 1'b1;
                        r_clr_ptr <= '0;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign w_wr_in_range = ({1'b0, i_wr_addr} < c_DEPTH);

    // While clearing, the sequencer owns the port and user writes are dropped.
    always_comb begin
        if (r_state == ST_CLEAR) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = r_clr_ptr;
            o_mem_wdata = '0;
            o_mem_be    = '1;
        end else begin
            o_mem_we    = i_wr_en && w_wr_in_range;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
            o_mem_be    = i_wr_be;
        end
    end

    assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : sram_dp_be
// Description : Simple-dual-port SRAM with byte enables, 1- or 2-cycle read
//               latency, selectable read-during-write policy and auto-clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int                  c_NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);

    logic                    w_ready;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [c_NBYTES-1:0]     w_mem_be;

    sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_wr_be     (wr_be),
        .o_ready     (w_ready),
        .o_mem_we    (w_mem_we),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata),
        .o_mem_be    (w_mem_be)
    );

    assign ready = w_ready;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    assign w_wr_old = r_mem[w_mem_addr];

    for (genvar b = 0; b < c_NBYTES; b++) begin : g_merge
        assign w_wr_merged[b*8 +: 8] =
            byte_merge(w_wr_old[b*8 +: 8], w_mem_wdata[b*8 +: 8], w_mem_be[b]);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_wr_merged;
        end
    end

    logic                  w_rd_go;
    logic                  w_rd_in_range;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  r_rd_v1;
    logic [DATA_WIDTH-1:0] r_rd_d1;

    assign w_rd_go       = rd_en && w_ready;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);
    assign w_collide     = w_mem_we && (w_mem_addr == rd_addr);

    // Array read sees the pre-edge contents, so old-data mode needs no bypass.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if ((RDW_MODE == RDW_NEW) && w_collide) begin
                w_rd_word = w_wr_merged;
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1 <= 1'b0;
            r_rd_d1 <= '0;
        end else begin
            r_rd_v1 <= w_rd_go;
            if (w_rd_go) begin
                r_rd_d1 <= w_rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_rd_v2;
        logic [DATA_WIDTH-1:0] r_rd_d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_v2 <= 1'b0;
                r_rd_d2 <= '0;
            end else begin
                r_rd_v2 <= r_rd_v1;
                if (r_rd_v1) begin
                    r_rd_d2 <= r_rd_d1;
                end
            end
        end

        assign rd_valid = r_rd_v2;
        assign rd_data  = r_rd_d2;
    end else begin : g_lat1
        assign rd_valid = r_rd_v1;
        assign rd_data  = r_rd_d1;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_dp_be
// Description : Directed bench; dut0 = latency 1 / old-data / 256 words,
//               dut1 = latency 2 / new-data / 200 words, sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic        ready0, ready1;
    logic        valid0, valid1;
    logic [31:0] data0, data1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_dp_be #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .READ_LATENCY(1), .RDW_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data0), .rd_valid(valid0)
    );

    sram_dp_be #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .READ_LATENCY(2), .RDW_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data1), .rd_valid(valid1)
    );

    typedef struct packed {
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic w, input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be,
        input logic r, input logic [7:0] ra,
        input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1
    );
        vec_t v;
        v.wr_en = w;  v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
        v.rd_en = r;  v.rd_addr = ra;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    initial begin
        int rise0, rise1, pulses;
        logic [31:0] exp1;

        vecs[0]  = mk(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h00, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 8'h10, 32'h000000AA, 4'h1, 1, 8'h00, 1, 32'h0,        1, 32'h0);
        vecs[2]  = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 1, 32'hDEADBEAA, 1, 32'hDEADBEAA);
        vecs[3]  = mk(1, 8'h20, 32'h11111111, 4'hF, 1, 8'h11, 1, 32'h0,        1, 32'h0);
        vecs[4]  = mk(1, 8'h20, 32'h22222222, 4'h3, 1, 8'h20, 1, 32'h11111111, 1, 32'h11112222);
        vecs[5]  = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h20, 1, 32'h11112222, 1, 32'h11112222);
        vecs[6]  = mk(1, 8'hFA, 32'h12345678, 4'hF, 0, 8'h00, 0, 32'h11112222, 0, 32'h11112222);
        vecs[7]  = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'hFA, 1, 32'h12345678, 1, 32'h0);
        vecs[8]  = mk(1, 8'h30, 32'hAABBCCDD, 4'h0, 1, 8'h30, 1, 32'h0,        1, 32'h0);
        vecs[9]  = mk(1, 8'h30, 32'hCAFEF00D, 4'hC, 1, 8'h10, 1, 32'hDEADBEAA, 1, 32'hDEADBEAA);
        vecs[10] = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h30, 1, 32'hCAFE0000, 1, 32'hCAFE0000);
        vecs[11] = mk(0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 0, 32'hCAFE0000, 0, 32'hCAFE0000);
        vecs[12] = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'hFA, 1, 32'h12345678, 1, 32'h0);
        vecs[13] = mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h32, 1, 32'h0,        1, 32'h0);

        // Reset state
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready0", {31'b0, ready0}, 32'h0);
        check("rst_ready1", {31'b0, ready1}, 32'h0);
        check("rst_valid0", {31'b0, valid0}, 32'h0);
        check("rst_valid1", {31'b0, valid1}, 32'h0);
        check("rst_data0", data0, 32'h0);
        check("rst_data1", data1, 32'h0);

        // Initial clear: ready must rise on the DEPTH-th edge with rst low
        rst = 1'b0;
        rise0 = 0; rise1 = 0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            if (ready0 && rise0 == 0) rise0 = e;
            if (ready1 && rise1 == 0) rise1 = e;
        end
        check("init_rise0", rise0, 32'd256);
        check("init_rise1", rise1, 32'd200);

        // Every address reads back zero after clear
        for (int a = 0; a < 256; a++) begin
            rd_en = 1'b1; rd_addr = 8'(a);
            tick();
            check("clr_valid0", {31'b0, valid0}, 32'h1);
            check("clr_data0", data0, 32'h0);
            check("clr_data1", data1, 32'h0);
        end
        idle();

        // Directed vectors; dut1 output trails dut0 by one cycle
        for (int i = 0; i < NV; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data; wr_be = vecs[i].wr_be;
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            tick();
            check($sformatf("vec%0d_valid0", i), {31'b0, valid0}, {31'b0, vecs[i].v0});
            check($sformatf("vec%0d_data0", i), data0, vecs[i].d0);
            if (i > 0) begin
                check($sformatf("vec%0d_valid1", i-1), {31'b0, valid1}, {31'b0, vecs[i-1].v1});
                check($sformatf("vec%0d_data1", i-1), data1, vecs[i-1].d1);
            end
        end
        idle();
        tick();
        check("vec13_valid1", {31'b0, valid1}, {31'b0, vecs[NV-1].v1});
        check("vec13_data1", data1, vecs[NV-1].d1);

        // Back-to-back read burst of addresses 0..7
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 8'(a); wr_data = 32'hA0 + 32'(a); wr_be = 4'hF;
            tick();
        end
        idle();
        for (int c = 0; c < 10; c++) begin
            rd_en = (c < 8); rd_addr = 8'(c);
            tick();
            check($sformatf("burst%0d_valid0", c), {31'b0, valid0}, {31'b0, (c < 8)});
            check($sformatf("burst%0d_data0", c), data0, (c < 8) ? 32'hA0 + 32'(c) : 32'hA7);
            exp1 = (c == 0) ? 32'h0 : (c >= 9) ? 32'hA7 : 32'hA0 + 32'(c - 1);
            check($sformatf("burst%0d_valid1", c), {31'b0, valid1}, {31'b0, (c >= 1 && c <= 8)});
            check($sformatf("burst%0d_data1", c), data1, exp1);
        end
        idle();

        // Reset while dut1 has a read in flight
        rd_en = 1'b1; rd_addr = 8'd3;
        tick();
        check("inflight_valid0", {31'b0, valid0}, 32'h1);
        check("inflight_data0", data0, 32'hA3);
        check("inflight_valid1", {31'b0, valid1}, 32'h0);
        idle();
        rst = 1'b1;
        pulses = 0;
        tick();
        if (valid1) pulses++;
        check("rst2_valid0", {31'b0, valid0}, 32'h0);
        check("rst2_data1", data1, 32'h0);
        check("rst2_ready0", {31'b0, ready0}, 32'h0);

        // Requests during clear are ignored; then reset again at clr_ptr=100
        rst = 1'b0;
        rd_en = 1'b1; rd_addr = 8'h05;
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (valid0 || valid1) pulses++;
        end
        check("midclr_ready1", {31'b0, ready1}, 32'h0);
        idle();
        rst = 1'b1;
        tick();
        if (valid0 || valid1) pulses++;
        rst = 1'b0;
        rise0 = 0; rise1 = 0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            if (valid0 || valid1) pulses++;
            if (ready0 && rise0 == 0) rise0 = e;
            if (ready1 && rise1 == 0) rise1 = e;
        end
        check("no_valid_pulses", pulses, 32'd0);
        check("reclr_rise0", rise0, 32'd256);
        check("reclr_rise1", rise1, 32'd200);

        // Contents cleared again, and the write issued during CLEAR was dropped
        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        check("post_valid0", {31'b0, valid0}, 32'h1);
        check("post_data0", data0, 32'h0);
        rd_en = 1'b1; rd_addr = 8'h20;
        tick();
        check("post_valid1", {31'b0, valid1}, 32'h1);
        check("post_data1", data1, 32'h0);
        check("post20_data0", data0, 32'h0);
        idle();
        tick();
        check("post20_data1", data1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
